dac_spi_loader: RTL

Receives a DAC code over a 3-wire SPI-style link (mode 0, MSB first) and presents it as the parallel 10-bit `serial_val` word that feeds the DAC bit-split stage. All SPI pins are asynchronous to `clk`. They are synchronised and edge-detected, and a complete, well-formed frame is committed atomically to the output register on chip-select release. Malformed frames are discarded and flagged, and never reach the DAC.

---
 rtl/dac_spi_loader_if.sv | 28 ++
 rtl/dac_spi_loader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dac_spi_loader_if.sv
// dac_spi_loader_if: bundles the asynchronous 3-wire SPI pins and the
// parallel DAC-code outputs of dac_spi_loader.
//   spi_sclk/spi_cs_n/spi_mosi : SPI mode-0 link (async to clk), into loader
//   serial_val                 : committed WIDTH-bit DAC code
//   val_update / frame_err     : one-cycle commit / discard pulses
//   busy                       : frame in progress
// master = SPI source / DAC consumer side, slave = the loader.
interface dac_spi_loader_if #(
  parameter int WIDTH = 10
);
  logic             spi_sclk;
  logic             spi_cs_n;
  logic             spi_mosi;
  logic [WIDTH-1:0] serial_val;
  logic             val_update;
  logic             frame_err;
  logic             busy;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  serial_val, val_update, frame_err, busy
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output serial_val, val_update, frame_err, busy
  );
endinterface

// File: rtl/dac_spi_loader.sv
// dac_spi_loader: receives a WIDTH-bit DAC code over SPI mode 0 (MSB first),
// synchronises the pins into clk, and commits a well-formed frame atomically
// to serial_val on chip-select release. Short and overrun frames are dropped
// and flagged with frame_err.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : dac_spi_loader_if.slave (SPI pins in, code/pulses/busy out)
module dac_spi_loader #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  dac_spi_loader_if.slave  bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS, DROP} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [SW-1:0]          settle_q;
  logic                   sclk_s, cs_s, mosi_s, edges_ok;
  logic                   sclk_rise, cs_fall, cs_rise;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [BW-1:0]          bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]       serial_val_q, serial_val_d;
  logic                   val_update_q, val_update_d;
  logic                   frame_err_q, frame_err_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Synchroniser chains restart at idle levels after reset; edges are only
  // trusted once the real pin level has propagated through the chain and the
  // previous-value registers, so a cs_n held low across reset exit does not
  // look like a falling edge.
  assign edges_ok  = (settle_q == SW'(SYNC_STAGES + 1));
  assign sclk_rise = edges_ok &  sclk_s & ~sclk_prev_q;
  assign cs_fall   = edges_ok & ~cs_s   &  cs_prev_q;
  assign cs_rise   = edges_ok &  cs_s   & ~cs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (!edges_ok) settle_q <= settle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      serial_val_q <= '0;
      val_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      serial_val_q <= serial_val_d;
      val_update_q <= val_update_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // cs_rise is tested before sclk_rise in every state so a coincident sclk
  // edge is ignored.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    serial_val_d = serial_val_q;
    val_update_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[WIDTH-2:0], mosi_s};
          if (bitcnt_q != BW'(WIDTH)) bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BW'(WIDTH - 1)) state_d = WAIT_CS;
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          serial_val_d = shreg_q;
          val_update_d = 1'b1;
          state_d      = IDLE;
        end else if (sclk_rise) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.serial_val = serial_val_q;
  assign bus.val_update = val_update_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
